// File: rtl/kmap_sweep_ctrl.sv
// ============================================================================
// Module   : kmap_sweep_ctrl
// Purpose  : On-chip self-check sequencer for a combinational XW-input
//            function unit.  Sweeps every input combination on x, samples
//            the unit's output f after SETTLE cycles, builds the captured
//            truth table and compares it against an expected table latched
//            at start.
// Revision : 1.0 - initial release
//
// Ports
//   clk        in   1     clock, all state on rising edge
//   areset_n   in   1     asynchronous active-low reset (sync release)
//   start      in   1     request a sweep; accepted only in IDLE
//   exp_table  in   N     expected truth table, bit i = f(x=i)
//   x          out  XW    registered stimulus to the function unit
//   f          in   1     function unit output
//   busy       out  1     high while sweeping
//   done       out  1     one-cycle pulse, results valid
//   cap_table  out  N     captured truth table, bit i = sampled f for x=i
//   mismatch   out  N     bit i set when cap_table[i] != expected[i]
//   err_cnt    out  XW+1  number of set mismatch bits (0..N)
//   pass       out  1     err_cnt == 0 at end of last sweep
//
// The expected/captured tables are named exp_table/cap_table because
// "expect" and "table" are reserved words in SystemVerilog.
//
// Build option
//   SWEEP_GRAY_EN : when defined, x follows the reflected Gray code so only
//                   one bit toggles per step; otherwise x ascends in binary.
// ============================================================================
`default_nettype none

module kmap_sweep_ctrl #(
  parameter int XW     = 4,
  parameter int SETTLE = 1,
  localparam int N     = 1 << XW
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          start,
  input  logic [N-1:0]  exp_table,
  output logic [XW-1:0] x,
  input  logic          f,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  cap_table,
  output logic [XW:0]   err_cnt,
  output logic [N-1:0]  mismatch,
  output logic          pass
);

  // Settle counter only needs to reach SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [XW-1:0] IDX_LAST    = {XW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [XW-1:0]   idx;        // binary step number within the sweep
  logic [N-1:0]    exp_q;      // expected table frozen at start

  logic            sample;
  logic            last;
  logic            miss;
  logic [XW:0]     err_next;

  // Step number -> x value.  Tables stay indexed by the binary value of x,
  // so the Gray build yields the same table as the binary build.
  function automatic logic [XW-1:0] sweep_map(input logic [XW-1:0] b);
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  assign sample   = (settle_cnt == SETTLE_LAST);
  assign last     = (idx == IDX_LAST);
  assign miss     = f ^ exp_q[x];
  // Includes the current sample so pass reflects the final count.
  assign err_next = err_cnt + {{XW{1'b0}}, miss};

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      idx        <= '0;
      exp_q      <= '0;
      x          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cap_table  <= '0;
      mismatch   <= '0;
      err_cnt    <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= RUN;
            idx        <= '0;
            x          <= sweep_map('0);
            cap_table  <= '0;
            mismatch   <= '0;
            err_cnt    <= '0;
            exp_q      <= exp_table;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end

        RUN: begin
          if (sample) begin
            settle_cnt   <= '0;
            cap_table[x] <= f;
            if (miss) begin
              mismatch[x] <= 1'b1;
            end
            err_cnt <= err_next;
            if (last) begin
              // x keeps the last value until the next accepted start.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              idx <= idx + 1'b1;
              x   <= sweep_map(idx + 1'b1);
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kmap_sweep_ctrl.sv
// ============================================================================
// Module   : tb_kmap_sweep_ctrl
// Purpose  : Self-checking bench for kmap_sweep_ctrl.  Two instances share
//            the clock and reset: dut_a with SETTLE=1 and dut_b with
//            SETTLE=3.  Each function unit is modelled as a lookup into a
//            bench-owned truth table.  Expected sweep results are queued
//            when a sweep is started and popped when done is observed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kmap_sweep_ctrl;

  logic clk = 1'b0;
  logic areset_n = 1'b0;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [15:0] tt_a = '0, tt_b = '0;
  logic [3:0]  x_a, x_b;
  logic        f_a, f_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tab_a, tab_b, mm_a, mm_b;
  logic [4:0]  ec_a, ec_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] tab;
    logic [15:0] mm;
    logic [4:0]  cnt;
    logic        pass;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always_comb f_a = tt_a[x_a];
  always_comb f_b = tt_b[x_b];

  kmap_sweep_ctrl #(.XW(4), .SETTLE(1)) dut_a (
    .clk(clk), .areset_n(areset_n), .start(start_a), .exp_table(exp_a),
    .x(x_a), .f(f_a), .busy(busy_a), .done(done_a), .cap_table(tab_a),
    .err_cnt(ec_a), .mismatch(mm_a), .pass(pass_a)
  );

  kmap_sweep_ctrl #(.XW(4), .SETTLE(3)) dut_b (
    .clk(clk), .areset_n(areset_n), .start(start_b), .exp_table(exp_b),
    .x(x_b), .f(f_b), .busy(busy_b), .done(done_b), .cap_table(tab_b),
    .err_cnt(ec_b), .mismatch(mm_b), .pass(pass_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] seq(input int i);
    logic [3:0] b;
    b = i[3:0];
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check_zero(input string who, input bit which);
    check({who, "_x"},    which ? x_b    : x_a,    0);
    check({who, "_busy"}, which ? busy_b : busy_a, 0);
    check({who, "_done"}, which ? done_b : done_a, 0);
    check({who, "_tab"},  which ? tab_b  : tab_a,  0);
    check({who, "_mm"},   which ? mm_b   : mm_a,   0);
    check({who, "_ec"},   which ? ec_b   : ec_a,   0);
    check({who, "_pass"}, which ? pass_b : pass_a, 0);
  endtask

  // One sweep on dut_a (which=0) or dut_b (which=1).  extras pulses start and
  // disturbs the expected table mid-sweep; abort_at>=0 resets after that
  // many samples and checks the outputs clear immediately.
  task automatic sweep(input bit which, input logic [15:0] tt, input logic [15:0] ex,
                       input bit extras, input int abort_at);
    int   s;
    exp_t e;
    s = which ? 3 : 1;
    @(negedge clk);
    if (which) begin tt_b = tt; exp_b = ex; start_b = 1'b1; end
    else       begin tt_a = tt; exp_a = ex; start_a = 1'b1; end
    sb.push_back('{tab: tt, mm: tt ^ ex, cnt: 5'($countones(tt ^ ex)), pass: (tt == ex)});
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < 16 * s; k++) begin
      check("x_step", which ? x_b : x_a, seq(k / s));
      check("busy_run", which ? busy_b : busy_a, 1);
      check("done_run", which ? done_b : done_a, 0);
      if (abort_at == k) begin
        areset_n = 1'b0;
        #1;
        check_zero("abort", which);
        void'(sb.pop_back());
        @(negedge clk);
        areset_n = 1'b1;
        return;
      end
      if (extras && (k == 3 || k == 15)) begin
        start_a = 1'b1; exp_a = ~ex;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    check("done_pulse", which ? done_b : done_a, 1);
    check("busy_end",   which ? busy_b : busy_a, 0);
    check("x_hold",     which ? x_b : x_a, seq(15));
    e = sb.pop_front();
    check("table",    which ? tab_b  : tab_a,  e.tab);
    check("mismatch", which ? mm_b   : mm_a,   e.mm);
    check("err_cnt",  which ? ec_b   : ec_a,   e.cnt);
    check("pass",     which ? pass_b : pass_a, e.pass);
    @(negedge clk);
    check("done_clr", which ? done_b : done_a, 0);
    check("busy_idle", which ? busy_b : busy_a, 0);
    check("table_hold", which ? tab_b : tab_a, e.tab);
  endtask

  initial begin
    // Reset held with start asserted: everything stays cleared.
    areset_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst_a", 1'b0);
    check_zero("rst_b", 1'b1);
    areset_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy_a, 0);
    check("idle_x", x_a, 0);
    check("idle_done", done_a, 0);

    sweep(1'b0, 16'h8000, 16'h8000, 1'b0, -1);   // f = &x, all match
    sweep(1'b0, 16'hAAAA, 16'h0000, 1'b0, -1);   // f = x[0], 8 errors
    sweep(1'b0, 16'hFFFF, 16'h0000, 1'b0, -1);   // every minterm wrong
    sweep(1'b0, 16'h6996, 16'h1234, 1'b1, -1);   // ignored starts, expect change
    sweep(1'b0, 16'hF0F0, 16'h0F0F, 1'b0, 5);    // reset after 5 samples
    sweep(1'b0, 16'hF0F0, 16'hF0F1, 1'b0, -1);   // full sweep after abort
    sweep(1'b1, 16'h8000, 16'h8000, 1'b0, -1);   // SETTLE=3
    sweep(1'b1, 16'hAAAA, 16'hAAA0, 1'b0, -1);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
